mem_arbiter: RTL

Arbitrates the instruction cache and the data cache for the single main-memory port, one full cache line per transaction. Sits directly upstream of the instruction cache: it drives the cache's service-ready strobe and the 256-bit line used for refill. It also serves data-cache line reads and write-backs, latching the granted request, running a memReq/memAck handshake, and returning the line with a one-cycle ready pulse.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_register.sv | 18 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arbiter_pkg;

    localparam int CACHE_LINE_WIDTH = 256;
    localparam int ADDR_WIDTH       = 16;
    localparam int LINE_OFFSET      = 4;   // 16 words per line
    localparam int LINE_ADDR_WIDTH  = ADDR_WIDTH - LINE_OFFSET;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // Everything captured at grant time; held stable for the whole access.
    typedef struct packed {
        req_id_e                     id;
        logic                        we;
        logic [LINE_ADDR_WIDTH-1:0]  addr;
        logic [CACHE_LINE_WIDTH-1:0] wdata;
    } grant_t;

    // Round-robin pick: on a tie the requester not served last wins.
    function automatic req_id_e pick_requester(input logic ic, input logic dc,
                                               input req_id_e last);
        if (ic && dc) return (last == REQ_DC) ? REQ_IC : REQ_DC;
        else if (ic)  return REQ_IC;
        else          return REQ_DC;
    endfunction

endpackage

// File: rtl/mem_arbiter_register.sv
// Generic enabled register with asynchronous active-low clear.
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; clear immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        icPetition,
    input  logic [ADDR_WIDTH-1:0]       icAddr,
    input  logic                        dcPetition,
    input  logic [ADDR_WIDTH-1:0]       dcAddr,
    input  logic                        dcWrite,
    input  logic [CACHE_LINE_WIDTH-1:0] dcWriteData,
    output logic                        icServiceReady,
    output logic                        dcServiceReady,
    output logic [CACHE_LINE_WIDTH-1:0] lineData,
    output logic                        memReq,
    output logic                        memWe,
    output logic [LINE_ADDR_WIDTH-1:0]  memAddr,
    output logic [CACHE_LINE_WIDTH-1:0] memWriteData,
    input  logic                        memAck,
    input  logic [CACHE_LINE_WIDTH-1:0] memReadData
);

    state_e  state_q, state_d;
    req_id_e last_grant_q, last_grant_d;

    grant_t  grant_d, grant_q;
    logic    grant_en;
    logic    line_en;
    logic [CACHE_LINE_WIDTH-1:0] line_q;

    // Word-offset bits never reach memory; transfers are whole lines.
    logic unused_offset;
    assign unused_offset = ^{icAddr[LINE_OFFSET-1:0], dcAddr[LINE_OFFSET-1:0]};

    // Candidate grant built from the current petitions; only loaded in IDLE.
    always_comb begin
        grant_d       = '0;
        grant_d.id    = pick_requester(icPetition, dcPetition, last_grant_q);
        grant_d.addr  = (grant_d.id == REQ_IC) ? icAddr[ADDR_WIDTH-1:LINE_OFFSET]
                                               : dcAddr[ADDR_WIDTH-1:LINE_OFFSET];
        grant_d.we    = (grant_d.id == REQ_DC) && dcWrite;
        grant_d.wdata = dcWriteData;
    end

    // State and round-robin history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_DC;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic and latch enables for grant and line buffers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_en     = 1'b0;
        line_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (icPetition || dcPetition) begin
                    grant_en = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (memAck) begin
                    // A write-back leaves the previously returned line intact.
                    line_en = !grant_q.we;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                last_grant_d = grant_q.id;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    register #(.WIDTH($bits(grant_t))) u_grant_reg (
        .clk   (clk),
        .reset (reset),
        .en    (grant_en),
        .d     (grant_d),
        .q     (grant_q)
    );

    register #(.WIDTH(CACHE_LINE_WIDTH)) u_line_reg (
        .clk   (clk),
        .reset (reset),
        .en    (line_en),
        .d     (memReadData),
        .q     (line_q)
    );

    // Outputs decode state and registered grant only; reset clears state,
    // so memReq drops asynchronously with it.
    assign memReq         = (state_q == ACCESS);
    assign memWe          = memReq && grant_q.we;
    assign memAddr        = grant_q.addr;
    assign memWriteData   = grant_q.wdata;
    assign icServiceReady = (state_q == RESPOND) && (grant_q.id == REQ_IC);
    assign dcServiceReady = (state_q == RESPOND) && (grant_q.id == REQ_DC);
    assign lineData       = line_q;

endmodule
